time_set_controller: RTL and testbench

Front-end sequencer for the 24-hour clock's timekeeping core.
- Synchronizes and debounces the five board pushbuttons.
- Runs the RUN / SET_MIN / SET_HR mode FSM and keeps shadow hour/minute registers for editing.
- Issues a one-cycle load to the timekeeper and gates its counting.
- Drives per-digit blink control to the seven-segment driver.

---
 rtl/time_set_controller.sv | 188 ++++++++++++++++++
 tb/tb_time_set_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/time_set_controller.sv
// Front-end sequencer for the 24-hour clock: button conditioning, RUN/SET_MIN/SET_HR FSM, shadow time and blink.
// Optional feature macro: AUTO_REPEAT_EN enables up/down auto-repeat while a button stays held.
module time_set_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 25_000_000,
  parameter int BLINK_HALF      = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_center,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic [4:0] cur_hrs,
  input  logic [5:0] cur_min,
  output logic [4:0] set_hrs,
  output logic [5:0] set_min,
  output logic       load,
  output logic       run_en,
  output logic [3:0] blink_mask,
  output logic       mode_led
);
  localparam int BtnC = 4;
  localparam int BtnL = 3;
  localparam int BtnR = 2;
  localparam int BtnU = 1;
  localparam int BtnD = 0;
  localparam int DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam int BkW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BkW-1:0] BkLast = BkW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {RUN = 2'd0, SET_MIN = 2'd1, SET_HR = 2'd2} state_e;

  state_e         state_q, state_d;
  logic [4:0]     setHrs_q, setHrs_d;
  logic [5:0]     setMin_q, setMin_d;
  logic           load_q, load_d;
  logic [4:0]     btnRaw, sync1_q, sync2_q, level_q, levelPrev_q, evt;
  logic [DbW-1:0] dbCnt_q [5];
  logic [BkW-1:0] blinkCnt_q;
  logic           blinkPhase_q, blinkRestart, edit, upAct, dnAct;
  logic           repUpStep, repDnStep;

  assign btnRaw = {btn_center, btn_left, btn_right, btn_up, btn_down};
  assign evt    = level_q & ~levelPrev_q;

  // A debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples disagree with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      levelPrev_q <= '0;
      for (int i = 0; i < 5; i++) dbCnt_q[i] <= '0;
    end else begin
      sync1_q     <= btnRaw;
      sync2_q     <= sync1_q;
      levelPrev_q <= level_q;
      for (int i = 0; i < 5; i++) begin
        if (sync2_q[i] == level_q[i]) begin
          dbCnt_q[i] <= '0;
        end else if (dbCnt_q[i] == DbLast) begin
          level_q[i] <= ~level_q[i];
          dbCnt_q[i] <= '0;
        end else begin
          dbCnt_q[i] <= dbCnt_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RpMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RpW   = $clog2(RpMax + 1);
  localparam logic [RpW-1:0] RpDelay = RpW'(REPEAT_DELAY);
  localparam logic [RpW-1:0] RpRate  = RpW'(REPEAT_RATE);

  logic [RpW-1:0] repCnt_q;
  logic           repActive_q, repUp_q, repFast_q, repHeld, repStep;

  assign repHeld   = repUp_q ? level_q[BtnU] : level_q[BtnD];
  assign repStep   = repActive_q && repHeld && (repCnt_q == (repFast_q ? RpRate : RpDelay));
  assign repUpStep = repStep && repUp_q;
  assign repDnStep = repStep && !repUp_q;

  // repCnt_q holds the number of cycles since the press event or since the last repeat step.
  always_ff @(posedge clk) begin
    if (rst || (state_d != state_q)) begin
      repCnt_q    <= '0;
      repActive_q <= 1'b0;
      repUp_q     <= 1'b0;
      repFast_q   <= 1'b0;
    end else if ((state_q != RUN) && (evt[BtnU] != evt[BtnD])) begin
      repCnt_q    <= RpW'(1);
      repActive_q <= 1'b1;
      repUp_q     <= evt[BtnU];
      repFast_q   <= 1'b0;
    end else if ((evt[BtnU] && evt[BtnD]) || !repHeld) begin
      repActive_q <= 1'b0;
    end else if (repStep) begin
      repCnt_q  <= RpW'(1);
      repFast_q <= 1'b1;
    end else if (repActive_q) begin
      repCnt_q <= repCnt_q + 1'b1;
    end
  end
`else
  assign repUpStep = 1'b0;
  assign repDnStep = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SET_MIN;
      setHrs_q <= '0;
      setMin_q <= '0;
      load_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      setHrs_q <= setHrs_d;
      setMin_q <= setMin_d;
      load_q   <= load_d;
    end
  end

  // One event acts per cycle: center beats left/right, which beat up/down; up and down together cancel.
  always_comb begin
    state_d  = state_q;
    setHrs_d = setHrs_q;
    setMin_d = setMin_q;
    load_d   = 1'b0;
    edit     = 1'b0;
    upAct    = evt[BtnU] || repUpStep;
    dnAct    = evt[BtnD] || repDnStep;
    case (state_q)
      RUN: begin
        if (evt[BtnC]) begin
          state_d  = SET_MIN;
          setHrs_d = (cur_hrs > 5'd23) ? 5'd0 : cur_hrs;
          setMin_d = (cur_min > 6'd59) ? 6'd0 : cur_min;
        end
      end
      SET_MIN, SET_HR: begin
        if (evt[BtnC]) begin
          state_d = RUN;
          load_d  = 1'b1;
        end else if (evt[BtnL] || evt[BtnR]) begin
          state_d = (state_q == SET_MIN) ? SET_HR : SET_MIN;
        end else if (upAct != dnAct) begin
          edit = 1'b1;
          if (state_q == SET_MIN) begin
            if (upAct) setMin_d = (setMin_q == 6'd59) ? 6'd0 : setMin_q + 6'd1;
            else       setMin_d = (setMin_q == 6'd0) ? 6'd59 : setMin_q - 6'd1;
          end else begin
            if (upAct) setHrs_d = (setHrs_q == 5'd23) ? 5'd0 : setHrs_q + 5'd1;
            else       setHrs_d = (setHrs_q == 5'd0) ? 5'd23 : setHrs_q - 5'd1;
          end
        end
      end
      default: state_d = SET_MIN;
    endcase
    blinkRestart = edit || (state_d != state_q);
  end

  // Editing or changing field restarts the blink with the digits visible.
  always_ff @(posedge clk) begin
    if (rst || blinkRestart) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= 1'b0;
    end else if (blinkCnt_q == BkLast) begin
      blinkCnt_q   <= '0;
      blinkPhase_q <= ~blinkPhase_q;
    end else begin
      blinkCnt_q <= blinkCnt_q + 1'b1;
    end
  end

  assign set_hrs    = setHrs_q;
  assign set_min    = setMin_q;
  assign load       = load_q;
  assign run_en     = (state_q == RUN);
  assign mode_led   = (state_q == RUN);
  assign blink_mask = (state_q == SET_MIN) ? {2'b00, {2{blinkPhase_q}}} :
                      (state_q == SET_HR)  ? {{2{blinkPhase_q}}, 2'b00} : 4'b0000;
endmodule

// File: tb/tb_time_set_controller.sv
// Self-checking bench for time_set_controller: directed scenarios plus random button presses
// checked against a press-level behavioural model. Honours AUTO_REPEAT_EN like the design.
`timescale 1ns/1ps
module tb_time_set_controller;
  localparam int DEB = 4;
  localparam int RDELAY = 20;
  localparam int RRATE = 5;
  localparam int BHALF = 8;
  localparam int B_C = 0, B_L = 1, B_R = 2, B_U = 3, B_D = 4;
  localparam int M_RUN = 0, M_MIN = 1, M_HR = 2;

  logic       clk, rst;
  logic       btn_center, btn_up, btn_down, btn_left, btn_right;
  logic [4:0] cur_hrs, set_hrs;
  logic [5:0] cur_min, set_min;
  logic       load, run_en, mode_led;
  logic [3:0] blink_mask;

  int errors = 0, checks = 0;
  int mState = M_MIN, mHrs = 0, mMin = 0, mLoads = 0, mLoadHrs = 0, mLoadMin = 0;
  int loadCount = 0, loadHrsSeen = 0, loadMinSeen = 0, loadRunEnSeen = 0;

  time_set_controller #(
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE), .BLINK_HALF(BHALF)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_center(btn_center), .btn_up(btn_up), .btn_down(btn_down),
    .btn_left(btn_left), .btn_right(btn_right),
    .cur_hrs(cur_hrs), .cur_min(cur_min),
    .set_hrs(set_hrs), .set_min(set_min), .load(load), .run_en(run_en),
    .blink_mask(blink_mask), .mode_led(mode_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (load) begin
      loadCount++;
      loadHrsSeen   = int'(set_hrs);
      loadMinSeen   = int'(set_min);
      loadRunEnSeen = int'(run_en);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setBtn(input int b, input logic v);
    case (b)
      B_C:     btn_center = v;
      B_L:     btn_left   = v;
      B_R:     btn_right  = v;
      B_U:     btn_up     = v;
      default: btn_down   = v;
    endcase
  endtask

  // Press-level model: a press held >= DEB cycles yields one event; with auto-repeat a hold
  // of H cycles keeps the debounced level high for H cycles, giving steps at 20, 25, ... < H.
  function automatic void modelPress(input int b, input int hold);
    int steps;
    if (hold < DEB) return;
    if (mState == M_RUN) begin
      if (b == B_C) begin
        mState = M_MIN;
        mHrs = (int'(cur_hrs) > 23) ? 0 : int'(cur_hrs);
        mMin = (int'(cur_min) > 59) ? 0 : int'(cur_min);
      end
    end else if (b == B_C) begin
      mState = M_RUN;
      mLoads++;
      mLoadHrs = mHrs;
      mLoadMin = mMin;
    end else if (b == B_L || b == B_R) begin
      mState = (mState == M_MIN) ? M_HR : M_MIN;
    end else begin
      steps = 1;
`ifdef AUTO_REPEAT_EN
      if (hold - 1 >= RDELAY) steps += 1 + (hold - 1 - RDELAY) / RRATE;
`endif
      if (b == B_D) steps = -steps;
      if (mState == M_MIN) mMin = ((mMin + steps) % 60 + 60) % 60;
      else                 mHrs = ((mHrs + steps) % 24 + 24) % 24;
    end
  endfunction

  task automatic checkState(input string tag);
    checkOutput({tag, "_hrs"}, int'(set_hrs), mHrs);
    checkOutput({tag, "_min"}, int'(set_min), mMin);
    checkOutput({tag, "_mode"}, int'(mode_led), (mState == M_RUN) ? 1 : 0);
    checkOutput({tag, "_run"}, int'(run_en), (mState == M_RUN) ? 1 : 0);
    checkOutput({tag, "_loads"}, loadCount, mLoads);
    checkOutput({tag, "_ldhrs"}, loadHrsSeen, mLoadHrs);
    checkOutput({tag, "_ldmin"}, loadMinSeen, mLoadMin);
    if (mState == M_RUN) checkOutput({tag, "_mask"}, int'(blink_mask), 0);
  endtask

  task automatic applyStimulus(input int b, input int hold);
    setBtn(b, 1'b1);
    repeat (hold) tick();
    setBtn(b, 1'b0);
    repeat (12) tick();
    modelPress(b, hold);
  endtask

  initial begin
    int prev, minBefore, b, hold, r;
    rst = 1'b1;
    {btn_center, btn_up, btn_down, btn_left, btn_right} = '0;
    cur_hrs = '0;
    cur_min = '0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("rst_hrs", int'(set_hrs), 0);
    checkOutput("rst_min", int'(set_min), 0);
    checkOutput("rst_load", int'(load), 0);
    checkOutput("rst_run", int'(run_en), 0);
    checkOutput("rst_mask", int'(blink_mask), 0);
    checkOutput("rst_mode", int'(mode_led), 0);

    applyStimulus(B_U, 3);
    checkOutput("t1_glitch", int'(set_min), 0);
    setBtn(B_U, 1'b1);
    repeat (6) tick();
    @(negedge clk);
    checkOutput("t1_cycle6", int'(set_min), 0);
    tick();
    @(negedge clk);
    checkOutput("t1_cycle7", int'(set_min), 1);
    repeat (3) tick();
    setBtn(B_U, 1'b0);
    repeat (12) tick();
    modelPress(B_U, 10);
    checkState("t1");

    applyStimulus(B_D, 6);
    applyStimulus(B_D, 6);
    checkOutput("t2_min59", int'(set_min), 59);
    applyStimulus(B_U, 6);
    checkOutput("t2_wrapmin", int'(set_min), 0);
    checkOutput("t2_nocarry", int'(set_hrs), 0);
    applyStimulus(B_R, 6);
    applyStimulus(B_D, 6);
    checkOutput("t2_wraphr", int'(set_hrs), 23);
    checkState("t2");

    repeat (10) applyStimulus(B_D, 5);
    applyStimulus(B_L, 5);
    repeat (15) applyStimulus(B_D, 5);
    checkState("t3_pre");
    prev = loadCount;
    applyStimulus(B_C, 6);
    checkOutput("t3_onepulse", loadCount - prev, 1);
    checkOutput("t3_ldhrs", loadHrsSeen, 13);
    checkOutput("t3_ldmin", loadMinSeen, 45);
    checkOutput("t3_runen_with_load", loadRunEnSeen, 1);
    checkState("t3");

    cur_hrs = 5'd7;
    cur_min = 6'd30;
    setBtn(B_C, 1'b1);
    repeat (6) tick();
    setBtn(B_C, 1'b0);
    tick();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t4_blink%0d", k), int'(blink_mask), ((k / BHALF) % 2 == 1) ? 3 : 0);
      tick();
    end
    repeat (12) tick();
    modelPress(B_C, 6);
    checkOutput("t4_hrs", int'(set_hrs), 7);
    checkOutput("t4_min", int'(set_min), 30);
    checkState("t4");

    applyStimulus(B_U, 41);
`ifdef AUTO_REPEAT_EN
    checkOutput("t5_repeat", int'(set_min), 36);
`else
    checkOutput("t5_repeat", int'(set_min), 31);
`endif
    checkState("t5");

    prev = loadCount;
    minBefore = int'(set_min);
    setBtn(B_C, 1'b1);
    setBtn(B_U, 1'b1);
    repeat (6) tick();
    setBtn(B_C, 1'b0);
    setBtn(B_U, 1'b0);
    repeat (12) tick();
    modelPress(B_C, 6);
    checkOutput("t6_pulse", loadCount - prev, 1);
    checkOutput("t6_nominchange", loadMinSeen, minBefore);
    checkState("t6a");
    cur_hrs = 5'd12;
    cur_min = 6'd34;
    applyStimulus(B_C, 6);
    checkState("t6b");
    prev = loadCount;
    setBtn(B_U, 1'b1);
    repeat (8) tick();
    rst = 1'b1;
    repeat (3) tick();
    setBtn(B_U, 1'b0);
    rst = 1'b0;
    checkOutput("t6_rst_hrs", int'(set_hrs), 0);
    checkOutput("t6_rst_min", int'(set_min), 0);
    checkOutput("t6_rst_load", int'(load), 0);
    checkOutput("t6_rst_run", int'(run_en), 0);
    checkOutput("t6_rst_mask", int'(blink_mask), 0);
    checkOutput("t6_rst_mode", int'(mode_led), 0);
    repeat (12) tick();
    mState = M_MIN;
    mHrs = 0;
    mMin = 0;
    checkOutput("t6_noload", loadCount, prev);
    checkState("t6c");

    for (int n = 0; n < 60; n++) begin
      b = int'($urandom_range(0, 4));
      r = int'($urandom_range(0, 9));
      if (r < 2)      hold = int'($urandom_range(1, 3));
      else if (r < 7) hold = int'($urandom_range(4, 12));
      else            hold = int'($urandom_range(20, 45));
      cur_hrs = 5'($urandom_range(0, 31));
      cur_min = 6'($urandom_range(0, 63));
      applyStimulus(b, hold);
      checkState($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
